// File: rtl/fetch_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module      : fetch_ctrl_pkg
// Description : Shared types and defaults for the fetch / run-control stage.
// Revision    : 1.0 - initial release
// ============================================================================
package fetch_ctrl_pkg;

  // Default program counter / instruction ROM address width.
  localparam int FETCH_PW_DEFAULT = 10;

  // Run-control states of the fetch stage.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } fetch_state_t;

endpackage : fetch_ctrl_pkg
`default_nettype wire

// File: rtl/fetch_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module      : fetch_ctrl_if
// Description : Harness/decoder <-> fetch stage signal bundle. The master side
//               is the harness plus decoder, the slave side is fetch_ctrl.
//               Optional macro FETCH_CYCLE_COUNT_EN adds CycleCount.
// Revision    : 1.0 - initial release
// ============================================================================
interface fetch_ctrl_if
  import fetch_ctrl_pkg::*;
#(
  parameter int W  = 8,
  parameter int PW = FETCH_PW_DEFAULT
);

  logic          Start;
  logic [PW-1:0] StartAddr;
  logic          BranchUp;
  logic          BranchDown;
  logic [W-1:0]  PCTarget;
  logic          Ack;
  logic [PW-1:0] InstrAddr;
  logic          Running;
  logic          Done;
`ifdef FETCH_CYCLE_COUNT_EN
  logic [15:0]   CycleCount;
`endif

  modport master (
    output Start, StartAddr, BranchUp, BranchDown, PCTarget, Ack,
`ifdef FETCH_CYCLE_COUNT_EN
    input  CycleCount,
`endif
    input  InstrAddr, Running, Done
  );

  modport slave (
    input  Start, StartAddr, BranchUp, BranchDown, PCTarget, Ack,
`ifdef FETCH_CYCLE_COUNT_EN
    output CycleCount,
`endif
    output InstrAddr, Running, Done
  );

endinterface : fetch_ctrl_if
`default_nettype wire

// File: rtl/fetch_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : fetch_ctrl
// Description : Program counter and Start/run/Done sequencing. Drives the
//               asynchronous instruction ROM address and consumes branch and
//               halt decisions from the decoder.
//               Optional macro FETCH_CYCLE_COUNT_EN adds a saturating 16-bit
//               RUN-cycle counter on CycleCount.
// Revision    : 1.0 - initial release
// ============================================================================
module fetch_ctrl
  import fetch_ctrl_pkg::*;
#(
  parameter int W  = 8,
  parameter int PW = FETCH_PW_DEFAULT
) (
  input  logic         Clk,
  input  logic         Reset,
  fetch_ctrl_if.slave  bus
);

  fetch_state_t  r_state;
  logic [PW-1:0] r_pc;
  logic          r_running;
  logic          r_done;
  logic [PW-1:0] w_target;
  logic [PW-1:0] w_next_pc;

  // Branch distance is unsigned, so it is zero-extended to PC width.
  assign w_target = PW'(bus.PCTarget);

  // Next PC in RUN; BranchDown wins if both branches are raised, and all
  // arithmetic wraps modulo 2**PW.
  always_comb begin
    w_next_pc = r_pc + PW'(1);
    if (bus.BranchDown) begin
      w_next_pc = r_pc + w_target;
    end else if (bus.BranchUp) begin
      w_next_pc = r_pc - w_target;
    end
  end

  // Run-control FSM with PC register; Start > Ack > branch > increment.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      r_state   <= IDLE;
      r_pc      <= '0;
      r_running <= 1'b0;
      r_done    <= 1'b0;
    end else begin
      case (r_state)
        IDLE, DONE: begin
          if (bus.Start) begin
            r_state   <= RUN;
            r_pc      <= bus.StartAddr;
            r_running <= 1'b1;
            r_done    <= 1'b0;
          end
        end
        RUN: begin
          if (bus.Start) begin
            r_pc <= bus.StartAddr;
          end else if (bus.Ack) begin
            // PC stays on the halt instruction address.
            r_state   <= DONE;
            r_running <= 1'b0;
            r_done    <= 1'b1;
          end else begin
            r_pc <= w_next_pc;
          end
        end
        default: begin
          r_state   <= IDLE;
          r_running <= 1'b0;
          r_done    <= 1'b0;
        end
      endcase
    end
  end

  assign bus.InstrAddr = r_pc;
  assign bus.Running   = r_running;
  assign bus.Done      = r_done;

`ifdef FETCH_CYCLE_COUNT_EN
  logic [15:0] r_cycle_count;

  // Counts cycles spent in RUN since the last accepted Start, saturating.
  always_ff @(posedge Clk) begin
    if (Reset || bus.Start) begin
      r_cycle_count <= '0;
    end else if (r_state == RUN && r_cycle_count != 16'hFFFF) begin
      r_cycle_count <= r_cycle_count + 16'd1;
    end
  end

  assign bus.CycleCount = r_cycle_count;
`endif

endmodule : fetch_ctrl
`default_nettype wire

// File: tb/tb_fetch_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_fetch_ctrl
// Description : Self-checking bench for fetch_ctrl. Directed steps followed by
//               random traffic, all compared against an abstract model of the
//               run-control rules. Honours FETCH_CYCLE_COUNT_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_fetch_ctrl;

  localparam int W     = 8;
  localparam int PW    = 10;
  localparam int PCMOD = 1 << PW;

  logic Clk;
  logic Reset;

  fetch_ctrl_if #(.W(W), .PW(PW)) bus ();

  fetch_ctrl #(.W(W), .PW(PW)) dut (
    .Clk   (Clk),
    .Reset (Reset),
    .bus   (bus.slave)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  // Reference model: the program counter as an integer plus two flags.
  int m_pc;
  bit m_running;
  bit m_done;
  int m_cnt;

  int n_chk;
  int n_pass;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    assert (got === exp) n_pass++;
    else $error("FAIL %s: observed %0d expected %0d", tag, got, exp);
  endtask

  task automatic check_all(input string tag);
    check({tag, ".InstrAddr"}, 32'(bus.InstrAddr), 32'(m_pc));
    check({tag, ".Running"},   32'(bus.Running),   32'(m_running));
    check({tag, ".Done"},      32'(bus.Done),      32'(m_done));
`ifdef FETCH_CYCLE_COUNT_EN
    check({tag, ".CycleCount"}, 32'(bus.CycleCount), 32'(m_cnt));
`endif
  endtask

  // One clock: drive inputs at the falling edge, advance the model at the
  // rising edge, then compare shortly after the edge.
  task automatic cyc(input string tag, input bit rst, input bit st, input int sa,
                     input bit bu, input bit bd, input int tg, input bit ak);
    @(negedge Clk);
    Reset          = rst;
    bus.Start      = st;
    bus.StartAddr  = PW'(sa);
    bus.BranchUp   = bu;
    bus.BranchDown = bd;
    bus.PCTarget   = W'(tg);
    bus.Ack        = ak;
    @(posedge Clk);
    if (rst) begin
      m_pc = 0; m_running = 0; m_done = 0; m_cnt = 0;
    end else if (st) begin
      m_pc = sa % PCMOD; m_running = 1; m_done = 0; m_cnt = 0;
    end else if (m_running) begin
      if (m_cnt < 65535) m_cnt = m_cnt + 1;
      if (ak) begin
        m_running = 0; m_done = 1;
      end else if (bd) begin
        m_pc = (m_pc + tg) % PCMOD;
      end else if (bu) begin
        m_pc = (m_pc - tg + PCMOD) % PCMOD;
      end else begin
        m_pc = (m_pc + 1) % PCMOD;
      end
    end
    #1;
    check_all(tag);
  endtask

  task automatic idle(input string tag);
    cyc(tag, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic start(input string tag, input int sa);
    cyc(tag, 0, 1, sa, 0, 0, 0, 0);
  endtask

  initial begin
    n_chk = 0; n_pass = 0;
    m_pc = 0; m_running = 0; m_done = 0; m_cnt = 0;
    Reset = 1'b1;
    bus.Start = 1'b0; bus.StartAddr = '0; bus.BranchUp = 1'b0;
    bus.BranchDown = 1'b0; bus.PCTarget = '0; bus.Ack = 1'b0;

    // Reset state
    cyc("reset0", 1, 0, 0, 0, 0, 0, 0);
    cyc("reset1", 1, 0, 0, 0, 0, 0, 0);
    // Branch/Ack ignored in IDLE
    cyc("idle_ign", 0, 0, 0, 1, 1, 50, 1);
    idle("idle_hold");

    // Start and sequential fetch
    start("start40", 40);
    idle("seq41"); idle("seq42"); idle("seq43");

    // Branches from PC=100
    start("start100", 100);
    cyc("bdown20", 0, 0, 0, 0, 1, 20, 0);
    cyc("bup5",    0, 0, 0, 1, 0, 5, 0);
    cyc("both3",   0, 0, 0, 1, 1, 3, 0);
    cyc("spin0",   0, 0, 0, 0, 1, 0, 0);

    // Wrap-around
    start("start1021", 1021);
    cyc("wrap_down", 0, 0, 0, 0, 1, 8, 0);
    start("start3", 3);
    cyc("wrap_up", 0, 0, 0, 1, 0, 10, 0);
    start("start1023", 1023);
    idle("wrap_inc");

    // Halt with a competing branch, then hold in DONE
    start("start57", 57);
    cyc("ack57", 0, 0, 0, 0, 1, 9, 1);
    for (int i = 0; i < 20; i++)
      cyc("done_hold", 0, 0, 0, i[0], ~i[0], i * 7, i[1]);
    start("restart200", 200);
    // Start in RUN overrides a simultaneous Ack
    cyc("start_over_ack", 0, 1, 600, 0, 0, 0, 1);

    // Reset mid-RUN discards the pending branch
    start("start300", 300);
    cyc("reset_run", 1, 0, 0, 0, 1, 40, 0);

    // RUN-cycle counter: 9 RUN cycles, the last one carrying Ack
    start("cnt_start", 500);
    for (int i = 0; i < 8; i++) idle("cnt_run");
    cyc("cnt_ack", 0, 0, 0, 0, 0, 0, 1);
    for (int i = 0; i < 4; i++) idle("cnt_hold");
`ifdef FETCH_CYCLE_COUNT_EN
    check("cnt_nine", 32'(bus.CycleCount), 32'd9);
`endif
    start("cnt_clear", 12);

    // Random traffic against the model
    for (int i = 0; i < 600; i++) begin
      cyc("rand",
          ($urandom_range(0, 59) == 0),
          ($urandom_range(0, 15) == 0),
          int'($urandom_range(0, PCMOD - 1)),
          1'($urandom_range(0, 1)),
          1'($urandom_range(0, 1)),
          ($urandom_range(0, 7) == 0) ? 0 : int'($urandom_range(0, 255)),
          ($urandom_range(0, 11) == 0));
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule : tb_fetch_ctrl
`default_nettype wire

// File: doc/fetch_ctrl.md
Name: fetch_ctrl

Overview:
- Program-counter and run-control stage, directly upstream of the control decoder/register file.
- Generates the instruction ROM address each cycle.
- Consumes the decoder's BranchUp/BranchDown/PCTarget and Ack outputs.
- Sequences the Start -> run -> Done handshake with the test harness.

Parameters:
- W, 8, width of PCTarget (register-file data width)
- PW, 10, program counter / instruction ROM address width

Ports:
- Clk  input  1  clock
- Reset  input  1  synchronous, active-high reset
- Start  input  1  one-cycle pulse; begin executing at StartAddr
- StartAddr  input  PW  program entry address, sampled on Start
- BranchUp  input  1  taken backward branch (PC decreases by PCTarget)
- BranchDown  input  1  taken forward branch (PC increases by PCTarget)
- PCTarget  input  W  unsigned branch distance
- Ack  input  1  halt instruction decoded this cycle
- InstrAddr  output  PW  current PC, drives instruction ROM address
- Running  output  1  high in RUN; the decoder gates register and memory writes with it
- Done  output  1  high in DONE; program finished

Behaviour:
- Reset is on Clk, synchronous, active-high, and dominates all other inputs.
- Reset state: IDLE, PC=0, Running=0, Done=0.
- Reset while in RUN: the next state is IDLE, and the in-flight branch or Ack is discarded.
- FSM states:
  - IDLE: hold PC. Start -> PC<=StartAddr, go RUN.
  - RUN: PC<=next_pc every cycle. Ack=1 -> go DONE, PC held at the Ack address. Start=1 -> PC<=StartAddr, stay RUN.
  - DONE: hold PC. Start -> PC<=StartAddr, go RUN.
- Priority in RUN: Start > Ack > branch > increment.
- next_pc calculation:
  - BranchDown: PC + zero-extended PCTarget.
  - BranchUp: PC - zero-extended PCTarget.
  - Otherwise: PC + 1.
  - All arithmetic is modulo 2**PW; wrap-around in both directions is legal and not flagged.
  - BranchUp and BranchDown both high is illegal; BranchDown wins.
  - PCTarget=0 on a taken branch holds the PC, producing an intentional spin.
- Branch inputs and Ack are ignored outside RUN.
- Output timing:
  - InstrAddr = PC, combinational from the register. The ROM is asynchronous, so the instruction at InstrAddr is decoded in the same cycle.
  - Running and Done are decoded from the state register, so each changes the cycle after the causing input is sampled.
  - Done drops the cycle after Start is sampled in DONE.
- Latency: Start sampled at edge n -> InstrAddr=StartAddr and Running=1 during cycle n+1.

Optional Feature:
- Macro: FETCH_CYCLE_COUNT_EN.
- With the macro defined:
  - Extra output CycleCount, 16 bits.
  - Cleared on Reset and on every accepted Start.
  - Increments once per RUN cycle, saturating at 16'hFFFF.
  - Frozen in DONE and IDLE.
- Without the macro: the port and the counter logic are absent; all other behaviour is identical.

Decomposition:
- Shared package definitions:
  - typedef enum logic[1:0] {IDLE, RUN, DONE} fetch_state_t.
  - Localparam for the default PW.
  - No other shared types.
- No sub-module: the next-PC adder/subtractor stays inline. The FSM and PC register are small enough for one module.

Test Plan:
- Reset, then Start with StartAddr=10'd40 -> InstrAddr=40 and Running=1 the next cycle; InstrAddr=41, 42, 43 on the following cycles.
- In RUN at PC=100: BranchDown with PCTarget=8'd20 -> PC=120; BranchUp with PCTarget=8'd5 -> PC=115; both asserted with PCTarget=3 -> PC=118.
- Wrap-around:
  - PC=1021, BranchDown, PCTarget=8 -> PC=5.
  - PC=3, BranchUp, PCTarget=10 -> PC=1017.
  - PC=1023, no branch -> PC=0.
- Halt and restart:
  - Ack at PC=57 together with BranchDown -> Done=1, Running=0 next cycle, PC held at 57 for 20 cycles.
  - Start with StartAddr=200 -> Running=1, Done=0, InstrAddr=200.
- Reset mid-RUN at PC=300 with BranchDown pending -> next cycle IDLE, PC=0, Running=0, Done=0.
- Run 9 RUN cycles then Ack -> CycleCount=9, held in DONE, cleared on the next Start.
  - Applies only when FETCH_CYCLE_COUNT_EN is defined.
  - Without the macro, the same stimulus must compile and the port must be absent.
